rs_relay_tail_buffer: RTL and testbench

RS_RELAY_TAIL_BUFFER -- requirements
Module: rs_relay_tail_buffer

---
 rtl/rs_relay_pkg.sv | 20 ++
 rtl/rs_relay_tail_mem.sv | 26 ++
 rtl/rs_relay_tail_buffer.sv | 98 +++++++++
 tb/tb_rs_relay_tail_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_relay_pkg.sv
// Shared helpers for the relay pipeline blocks: in-flight grace sizing and a
// constant-safe ceiling log2.
package rs_relay_pkg;

    // Words that can still arrive after full_n drops: the round trip through
    // the relay stages plus the cycle spent in the full_n register itself.
    function automatic int grace_of(input int pipeline_level);
        return 2 * pipeline_level + 1;
    endfunction

    function automatic int clog2_of(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/rs_relay_tail_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read so the head
// word is visible in the same cycle the read pointer points at it.
module rs_relay_tail_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs_relay_tail_buffer.sv
// Receiving end of a registered valid/full_n relay: keeps accepting in-flight
// words after full_n drops and presents them on a first-word-fall-through port.
module rs_relay_tail_buffer
    import rs_relay_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINE_LEVEL = 8,
    parameter int DEPTH          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    output logic                  overflow
);

    localparam int GRACE     = grace_of(PIPELINE_LEVEL);
    localparam int CW        = clog2_of(DEPTH + 1);
    localparam int AW        = clog2_of(DEPTH);
    localparam int FULL_MARK = DEPTH - GRACE;

    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          full_n_reg;
    logic          overflow_reg;
    logic          is_full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign is_full = (count_reg == CW'(DEPTH));
    assign pop     = if_read && (count_reg != '0) && !reset;
    // A pop in the same cycle frees the slot being written, so full+pop+write is legal.
    assign wr_en   = if_write && (!is_full || pop) && !reset;
    assign drop    = if_write && is_full && !pop && !reset;

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_en) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            full_n_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            full_n_reg   <= (count_next < CW'(FULL_MARK));
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    rs_relay_tail_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_reg),
        .wdata (if_din),
        .raddr (rd_ptr_reg),
        .rdata (if_dout)
    );

    assign if_full_n  = full_n_reg;
    assign if_empty_n = (count_reg != '0);
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_rs_relay_tail_buffer.sv
// Directed bench for the relay tail buffer at default parameters
// (DATA_WIDTH=32, PIPELINE_LEVEL=8, DEPTH=32, full_n threshold 15).
module tb_rs_relay_tail_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_write;
    logic [31:0] if_din;
    logic        if_full_n;
    logic        if_empty_n;
    logic [31:0] if_dout;
    logic        if_read;
    logic        overflow;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    rs_relay_tail_buffer #(
        .DATA_WIDTH     (32),
        .PIPELINE_LEVEL (8),
        .DEPTH          (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_empty_n (if_empty_n),
        .if_dout    (if_dout),
        .if_read    (if_read),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        if_write = 1'b1;
        if_din   = d;
        tick();
        if_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Pops until empty, comparing every head word against the expected queue.
    task automatic drain(input string tag);
        int          n;
        int          total;
        logic [31:0] e;
        n     = 0;
        total = exp_q.size();
        while (if_empty_n && n < 64) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check(tag, if_dout, e);
            if_read = 1'b1;
            tick();
            if_read = 1'b0;
            n++;
        end
        check({tag, "_count"}, 32'(n), 32'(total));
        exp_q.delete();
    endtask

    initial begin
        int writes;
        int after;
        int sent;
        int recv;
        bit seen;

        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;

        // Reset state, first-edge full_n, single-word latency
        tick();
        tick();
        check("rst_empty_n", 32'(if_empty_n), 32'd0);
        check("rst_full_n", 32'(if_full_n), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        check("c1_full_n", 32'(if_full_n), 32'd1);
        check("c1_empty_n", 32'(if_empty_n), 32'd0);
        push(32'hA5);
        check("c3_empty_n", 32'(if_empty_n), 32'd1);
        check("c3_dout", if_dout, 32'hA5);
        if_read = 1'b1;
        tick();
        if_read = 1'b0;
        check("pop_empty_n", 32'(if_empty_n), 32'd0);
        if_read = 1'b1;
        tick();
        if_read = 1'b0;
        check("read_when_empty", 32'(if_empty_n), 32'd0);

        // Back-pressure: full_n falls after write 15, sender stops 8 writes later
        do_reset();
        writes = 0;
        after  = 0;
        seen   = 1'b0;
        for (int c = 0; c < 100 && after < 8; c++) begin
            if_write = 1'b1;
            if_din   = 32'(writes + 1);
            exp_q.push_back(32'(writes + 1));
            tick();
            writes++;
            if (writes == 14) check("bp_full_n_w14", 32'(if_full_n), 32'd1);
            if (writes == 15) check("bp_full_n_w15", 32'(if_full_n), 32'd0);
            if (seen) after++;
            else if (!if_full_n) seen = 1'b1;
        end
        if_write = 1'b0;
        check("bp_writes_le31", 32'(writes <= 31), 32'd1);
        check("bp_overflow", 32'(overflow), 32'd0);
        drain("bp_drain");
        tick();
        check("bp_full_n_after", 32'(if_full_n), 32'd1);

        // Overflow: sender ignores full_n, word 33 is dropped
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            push(32'h100 + 32'(i));
            exp_q.push_back(32'h100 + 32'(i));
        end
        check("ov_before", 32'(overflow), 32'd0);
        check("ov_full_n", 32'(if_full_n), 32'd0);
        push(32'h1FF);
        check("ov_set", 32'(overflow), 32'd1);
        drain("ov_drain");
        check("ov_sticky", 32'(overflow), 32'd1);

        // Mid-operation reset with 10 words stored and overflow set
        for (int i = 1; i <= 10; i++) push(32'h400 + 32'(i));
        check("mr_empty_n_pre", 32'(if_empty_n), 32'd1);
        reset = 1'b1;
        tick();
        check("mr_empty_n", 32'(if_empty_n), 32'd0);
        check("mr_full_n", 32'(if_full_n), 32'd0);
        check("mr_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        check("mr_full_n_after", 32'(if_full_n), 32'd1);
        check("mr_empty_n_after", 32'(if_empty_n), 32'd0);

        // Full buffer with simultaneous write and pop
        for (int i = 1; i <= 32; i++) begin
            push(32'h200 + 32'(i));
            exp_q.push_back(32'h200 + 32'(i));
        end
        check("fp_head", if_dout, 32'h201);
        if_write = 1'b1;
        if_read  = 1'b1;
        if_din   = 32'h2FF;
        tick();
        if_write = 1'b0;
        if_read  = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h2FF);
        check("fp_overflow", 32'(overflow), 32'd0);
        check("fp_head_next", if_dout, 32'h202);
        drain("fp_drain");

        // Streaming with random reads across a pointer wrap
        do_reset();
        sent = 0;
        recv = 0;
        for (int c = 0; c < 1000 && recv < 40; c++) begin
            if_write = (sent < 40) && if_full_n;
            if_din   = 32'h300 + 32'(sent);
            if_read  = ($urandom_range(0, 1) == 1) && if_empty_n;
            if (if_read) begin
                check("st_word", if_dout, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
                recv++;
            end
            if (if_write) begin
                exp_q.push_back(if_din);
                sent++;
            end
            tick();
        end
        if_write = 1'b0;
        if_read  = 1'b0;
        check("st_recv", 32'(recv), 32'd40);
        check("st_empty", 32'(if_empty_n), 32'd0);
        check("st_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
